// File: rtl/scpu_pkg.sv
// Shared opcodes, field widths and instruction layout for the SCPU core.
package scpu_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned REG_W  = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned RIDX_W = 2;
    localparam int unsigned INSN_W = 16;
    localparam int unsigned NREGS  = 4;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS_MSB  = 9;
    localparam int unsigned RS_LSB  = 8;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_MOV  = 4'h9,
        OP_ADDI = 4'hA,
        OP_JMP  = 4'hB,
        OP_BEQZ = 4'hC,
        OP_OUT  = 4'hD,
        OP_HALT = 4'hE,
        OP_RSV  = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        opcode_e           opc;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] rs;
        logic [REG_W-1:0]  imm;
    } insn_t;

    // Split a raw instruction word into its fields.
    function automatic insn_t decode(logic [INSN_W-1:0] w);
        insn_t d;
        d.opc = opcode_e'(w[OPC_MSB:OPC_LSB]);
        d.rd  = w[RD_MSB:RD_LSB];
        d.rs  = w[RS_MSB:RS_LSB];
        d.imm = w[IMM_MSB:IMM_LSB];
        return d;
    endfunction

    // True for opcodes whose ALU result lands in rd.
    function automatic logic writes_rd(opcode_e op);
        logic w;
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_MOV, OP_ADDI: w = 1'b1;
            default:                         w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/scpu_alu.sv
// Combinational 8-bit datapath for the register-writing opcodes.
module scpu_alu
    import scpu_pkg::*;
(
    input  logic [OPC_W-1:0] opc_i,
    input  logic [REG_W-1:0] a_i,
    input  logic [REG_W-1:0] b_i,
    input  logic [REG_W-1:0] imm_i,
    output logic [REG_W-1:0] y_o
);

    opcode_e opc;
    assign opc = opcode_e'(opc_i);

    // Result selection; carries are discarded by the 8-bit width.
    always_comb begin
        y_o = a_i;
        case (opc)
            OP_LDI:  y_o = imm_i;
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SHL:  y_o = a_i << imm_i[2:0];
            OP_SHR:  y_o = a_i >> imm_i[2:0];
            OP_MOV:  y_o = b_i;
            OP_ADDI: y_o = a_i + imm_i;
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/scpu.sv
// Tiny single-cycle CPU: loadable instruction memory, four registers, OUT port.
module scpu
    import scpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   ins_index,
    input  logic                ins_we,
    input  logic [INSN_W-1:0]   instructs,
    output logic [REG_W-1:0]    res
);

    localparam int unsigned IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic [INSN_W-1:0] imem_q [IMEM_DEPTH];
    logic [INSN_W-1:0] fetch_word;
    insn_t             insn;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [REG_W-1:0]  regs_q [NREGS];
    logic [REG_W-1:0]  regs_d [NREGS];
    logic [REG_W-1:0]  res_q, res_d;

    logic [REG_W-1:0]  op_a, op_b, alu_y;

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ins_we && (32'(ins_index) < IMEM_DEPTH)) begin
            imem_q[IDX_W'(ins_index)] <= instructs;
        end
    end

    // Combinational fetch; out-of-range PC reads as NOP.
    assign fetch_word = (32'(pc_q) < IMEM_DEPTH) ? imem_q[IDX_W'(pc_q)] : '0;
    assign insn       = decode(fetch_word);
    assign op_a       = regs_q[insn.rd];
    assign op_b       = regs_q[insn.rs];

    scpu_alu u_alu (
        .opc_i (insn.opc),
        .a_i   (op_a),
        .b_i   (op_b),
        .imm_i (insn.imm),
        .y_o   (alu_y)
    );

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            res_q   <= '0;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            res_q   <= res_d;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= regs_d[i];
        end
    end

    // Next-state: loading holds the core at PC 0, otherwise execute one instruction.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        res_d   = res_q;
        regs_d  = regs_q;
        if (ins_we) begin
            pc_d    = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            pc_d = pc_q + ADDR_W'(1);
            case (insn.opc)
                OP_JMP:  pc_d = insn.imm;
                OP_BEQZ: if (op_a == '0) pc_d = insn.imm;
                OP_OUT:  res_d = op_a;
                OP_HALT: begin
                    state_d = ST_HALT;
                    pc_d    = pc_q;
                end
                default: ;
            endcase
            if (writes_rd(insn.opc)) regs_d[insn.rd] = alu_y;
        end
    end

    assign res = res_q;

endmodule

// File: tb/tb_scpu.sv
// Directed self-checking bench for the SCPU core.
module tb_scpu;
    import scpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ins_index;
    logic        ins_we;
    logic [15:0] instructs;
    logic [7:0]  res;

    int n_tests = 0;
    int n_fail  = 0;

    scpu #(.IMEM_DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_index (ins_index),
        .ins_we    (ins_we),
        .instructs (instructs),
        .res       (res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [15:0] data);
        ins_we    = 1'b1;
        ins_index = addr;
        instructs = data;
        @(posedge clk);
        #1;
    endtask

    task automatic release_we();
        ins_we = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ins_we    = 1'b1;
        ins_index = 8'd0;
        instructs = 16'h0000;
        #12;
        check("reset_res",    16'(res), 16'h00);
        check("reset_pc",     16'(dut.pc_q), 16'h00);
        check("reset_halted", 16'(dut.state_q), 16'(ST_RUN));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All-NOP image: clear, then the stride-2 load loop.
        for (int i = 0; i < 256; i++) wr(8'(i), 16'h0000);
        for (int i = 0; i < 128; i++) wr(8'(2 * i), 16'(i));
        release_we();
        run(300);
        check("nop_res",     16'(res), 16'h00);
        check("nop_pc_wrap", 16'(dut.pc_q), 16'd44);

        // LDI/LDI/ADD/OUT/HALT.
        wr(8'd0, 16'h1005);
        wr(8'd1, 16'h1403);
        wr(8'd2, 16'h2100);
        wr(8'd3, 16'hD000);
        wr(8'd4, 16'hE000);
        release_we();
        run(3);
        check("add_before_out", 16'(res), 16'h00);
        run(1);
        check("add_res", 16'(res), 16'h08);
        run(20);
        check("add_res_late", 16'(res), 16'h08);
        check("halt_pc",      16'(dut.pc_q), 16'd4);
        check("halt_flag",    16'(dut.state_q), 16'(ST_HALT));

        // Asynchronous reset mid-run, memory retained.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_res",    16'(res), 16'h00);
        check("arst_pc",     16'(dut.pc_q), 16'h00);
        check("arst_halted", 16'(dut.state_q), 16'(ST_RUN));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(3);
        check("rerun_before_out", 16'(res), 16'h00);
        run(1);
        check("rerun_res", 16'(res), 16'h08);
        run(2);
        check("rerun_halted", 16'(dut.state_q), 16'(ST_HALT));

        // Hold while halted clears halt and parks PC at 0.
        wr(8'd200, 16'hE000);
        check("hold_pc",     16'(dut.pc_q), 16'h00);
        check("hold_halted", 16'(dut.state_q), 16'(ST_RUN));
        check("hold_res",    16'(res), 16'h08);
        release_we();
        run(2);
        check("resume_pc", 16'(dut.pc_q), 16'd2);

        // 0xFF + 2 wraps to 0x01.
        wr(8'd0, 16'h10FF);
        wr(8'd1, 16'hA002);
        wr(8'd2, 16'hD000);
        wr(8'd3, 16'hE000);
        release_we();
        run(2);
        check("addi_res_held", 16'(res), 16'h08);
        run(1);
        check("addi_wrap", 16'(res), 16'h01);

        // 0 - 1 wraps to 0xFF.
        wr(8'd0, 16'h1000);
        wr(8'd1, 16'h1401);
        wr(8'd2, 16'h3100);
        wr(8'd3, 16'hD000);
        wr(8'd4, 16'hE000);
        release_we();
        run(3);
        check("sub_res_held", 16'(res), 16'h01);
        run(1);
        check("sub_wrap", 16'(res), 16'hFF);

        // Countdown loop: exits after three decrements, OUT on cycle 10.
        wr(8'd0, 16'h1003);
        wr(8'd1, 16'hA0FF);
        wr(8'd2, 16'hC005);
        wr(8'd3, 16'hB001);
        wr(8'd4, 16'h0000);
        wr(8'd5, 16'hD000);
        wr(8'd6, 16'hE000);
        release_we();
        run(9);
        check("loop_res_held", 16'(res), 16'hFF);
        check("loop_pc_out",   16'(dut.pc_q), 16'd5);
        run(1);
        check("loop_res", 16'(res), 16'h00);
        run(1);
        check("loop_halt_pc", 16'(dut.pc_q), 16'd6);

        // XOR, MOV, SHL, SHR, OR, reserved opcode.
        wr(8'd0,  16'h10A5);
        wr(8'd1,  16'h140F);
        wr(8'd2,  16'h6100);
        wr(8'd3,  16'hD000);
        wr(8'd4,  16'h9800);
        wr(8'd5,  16'h7803);
        wr(8'd6,  16'hD800);
        wr(8'd7,  16'h8004);
        wr(8'd8,  16'h5100);
        wr(8'd9,  16'hD000);
        wr(8'd10, 16'hF000);
        wr(8'd11, 16'hE000);
        release_we();
        run(4);
        check("xor_res", 16'(res), 16'hAA);
        run(3);
        check("mov_shl_res", 16'(res), 16'h50);
        run(3);
        check("shr_or_res", 16'(res), 16'h0F);
        run(2);
        check("logic_halt_pc",   16'(dut.pc_q), 16'd11);
        check("logic_halt_flag", 16'(dut.state_q), 16'(ST_HALT));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
